// File: rtl/vx_gpu_pkg.sv
// rtl/vx_gpu_pkg.sv - shared width helpers and limits for the scoreboard slice
package vx_gpu_pkg;

  localparam int PERF_CTR_BITS = 32;
  localparam int STALL_TIMEOUT = 10000;

  // Index width that stays at least one bit for single-entry tables.
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Async counters must hold the value ASYNC_DEPTH itself.
  function automatic int async_cnt_w(input int depth);
    return clog2w(depth + 1);
  endfunction

endpackage

// File: rtl/vx_stream_buffer.sv
// rtl/vx_stream_buffer.sv - 2-entry skid buffer with registered input-side ready
module vx_stream_buffer #(
  parameter int DATAW = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data
);

  logic [1:0]       count;
  logic [DATAW-1:0] head;
  logic [DATAW-1:0] tail;
  logic             push;
  logic             pop;

  // Ready comes from occupancy alone, so upstream never sees out_ready combinationally.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    case ({push, pop})
      2'b10: begin
        if (count == 2'd0) head <= in_data;
        else               tail <= in_data;
      end
      2'b01: head <= tail;
      2'b11: begin
        if (count == 2'd1) begin
          head <= in_data;
        end else begin
          head <= tail;
          tail <= in_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vx_scoreboard_ctr.sv
// rtl/vx_scoreboard_ctr.sv - per-warp register/async scoreboard feeding a 2-entry staging buffer
// Define SCB_PERF_EN to add stall/fire/WAW performance counter outputs.
module vx_scoreboard_ctr
  import vx_gpu_pkg::*;
#(
  parameter int NUM_WIS     = 4,
  parameter int NUM_REGS    = 64,
  parameter int CNT_W       = 2,
  parameter int ALLOW_WAW   = 0,
  parameter int NUM_ASYNC   = 2,
  parameter int ASYNC_DEPTH = 1,
  parameter int DATAW       = 64,
  localparam int WIS_W      = clog2w(NUM_WIS),
  localparam int REG_W      = clog2w(NUM_REGS),
  localparam int ASYNC_W    = clog2w(NUM_ASYNC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATAW-1:0]   in_data,
  input  logic [WIS_W-1:0]   in_wis,
  input  logic [REG_W-1:0]   in_rd,
  input  logic [REG_W-1:0]   in_rs1,
  input  logic [REG_W-1:0]   in_rs2,
  input  logic [REG_W-1:0]   in_rs3,
  input  logic               in_wb,
  input  logic               in_async_start,
  input  logic               in_async_wait,
  input  logic [ASYNC_W-1:0] in_async_id,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATAW-1:0]   out_data,
  input  logic               wb_valid,
  input  logic               wb_eop,
  input  logic [WIS_W-1:0]   wb_wis,
  input  logic [REG_W-1:0]   wb_rd,
  input  logic               ad_valid,
  input  logic [WIS_W-1:0]   ad_wis,
  input  logic [ASYNC_W-1:0] ad_id
`ifdef SCB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_stalls,
  output logic [PERF_CTR_BITS-1:0] perf_fires,
  output logic [PERF_CTR_BITS-1:0] perf_waw_issues
`endif
);

  localparam int ACNT_W = async_cnt_w(ASYNC_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0]  reg_cnt   [NUM_WIS][NUM_REGS];
  logic [ACNT_W-1:0] async_cnt [NUM_WIS][NUM_ASYNC];

  logic [CNT_W-1:0]  rd_cnt;
  logic [ACNT_W-1:0] a_cnt;
  logic              rs_ok;
  logic              rd_ok;
  logic              async_ok;
  logic              operands_ready;
  logic              stage_ready;
  logic              fire;
  logic              inc_en;
  logic              dec_en;
  logic              dec_same;
  logic              ainc_en;
  logic              adec_same;

  assign rd_cnt = reg_cnt[in_wis][in_rd];
  assign a_cnt  = async_cnt[in_wis][in_async_id];

  assign rs_ok = (reg_cnt[in_wis][in_rs1] == '0) &&
                 (reg_cnt[in_wis][in_rs2] == '0) &&
                 (reg_cnt[in_wis][in_rs3] == '0);
  assign rd_ok = (ALLOW_WAW != 0) ? (rd_cnt != CNT_MAX) : (rd_cnt == '0);

  always_comb begin
    async_ok = 1'b1;
    if (in_async_wait)       async_ok = (a_cnt == '0);
    else if (in_async_start) async_ok = (32'(a_cnt) < ASYNC_DEPTH);
  end

  assign operands_ready = rs_ok && rd_ok && async_ok;
  assign in_ready       = operands_ready && stage_ready;
  assign fire           = in_valid && in_ready;

  // Register 0 is hardwired free: writes to it never allocate.
  assign inc_en    = fire && in_wb && (in_rd != '0);
  assign dec_en    = wb_valid && wb_eop;
  assign dec_same  = dec_en && (wb_wis == in_wis) && (wb_rd == in_rd);
  assign ainc_en   = fire && in_async_start;
  assign adec_same = ad_valid && (ad_wis == in_wis) && (ad_id == in_async_id);

  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WIS; w++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (reset) begin
          reg_cnt[w][r] <= '0;
        end else if (inc_en && (in_wis == WIS_W'(w)) && (in_rd == REG_W'(r))) begin
          if (!dec_same && (reg_cnt[w][r] != CNT_MAX))
            reg_cnt[w][r] <= reg_cnt[w][r] + CNT_W'(1);
        end else if (dec_en && (wb_wis == WIS_W'(w)) && (wb_rd == REG_W'(r)) &&
                     (reg_cnt[w][r] != '0)) begin
          reg_cnt[w][r] <= reg_cnt[w][r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WIS; w++) begin
      for (int a = 0; a < NUM_ASYNC; a++) begin
        if (reset) begin
          async_cnt[w][a] <= '0;
        end else if (ainc_en && (in_wis == WIS_W'(w)) && (in_async_id == ASYNC_W'(a))) begin
          if (!adec_same)
            async_cnt[w][a] <= async_cnt[w][a] + ACNT_W'(1);
        end else if (ad_valid && (ad_wis == WIS_W'(w)) && (ad_id == ASYNC_W'(a)) &&
                     (async_cnt[w][a] != '0)) begin
          async_cnt[w][a] <= async_cnt[w][a] - ACNT_W'(1);
        end
      end
    end
  end

  vx_stream_buffer #(
    .DATAW (DATAW)
  ) stage_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid && operands_ready),
    .in_ready  (stage_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

`ifdef SCB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls     <= '0;
      perf_fires      <= '0;
      perf_waw_issues <= '0;
    end else begin
      if (in_valid && !in_ready) perf_stalls <= perf_stalls + PERF_CTR_BITS'(1);
      if (fire)                  perf_fires  <= perf_fires + PERF_CTR_BITS'(1);
      if (fire && (rd_cnt != '0)) perf_waw_issues <= perf_waw_issues + PERF_CTR_BITS'(1);
    end
  end
`endif

`ifdef SIMULATION
  int unsigned stall_cycles;

  always_ff @(posedge clk) begin
    if (reset || !in_valid || in_ready) stall_cycles <= 0;
    else                                stall_cycles <= stall_cycles + 1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(dec_en && !dec_same && (reg_cnt[wb_wis][wb_rd] == '0)))
        else $error("scoreboard: writeback release of an idle register");
      assert (!(ad_valid && !(ainc_en && adec_same) && (async_cnt[ad_wis][ad_id] == '0)))
        else $error("scoreboard: async completion on an idle unit");
      assert (stall_cycles < STALL_TIMEOUT)
        else $error("scoreboard: issue stalled beyond timeout");
    end
  end
`endif

endmodule

// File: doc/vx_scoreboard_ctr.md
VX_SCOREBOARD_CTR -- requirements
Module: VX_scoreboard_ctr

Interface
REQ-001 SHALL have parameter NUM_WIS, default 4, meaning warps sharing this issue slice.
REQ-002 SHALL have parameter NUM_REGS, default 64, meaning tracked registers per warp.
REQ-003 SHALL have parameter CNT_W, default 2, meaning counter width for outstanding writes per register; max = 2^CNT_W-1.
REQ-004 SHALL have parameter ALLOW_WAW, default 0; 0 = block issue on rd busy, 1 = allow rd busy up to counter max.
REQ-005 SHALL have parameter NUM_ASYNC, default 2, meaning async (no-rd) units tracked per warp.
REQ-006 SHALL have parameter ASYNC_DEPTH, default 1, meaning max in-flight ops per warp per async unit.
REQ-007 SHALL have parameter DATAW, default 64, meaning opaque payload width.
REQ-008 clk  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-009 in_valid in 1, in_ready out 1, in_data in DATAW: issue-side handshake and payload.
REQ-010 in_wis in clog2(NUM_WIS); in_rd, in_rs1, in_rs2, in_rs3 in clog2(NUM_REGS); in_wb in 1: register fields.
REQ-011 in_async_start in 1, in_async_wait in 1, in_async_id in clog2(NUM_ASYNC): async start/wait qualifiers.
REQ-012 out_valid out 1, out_ready in 1, out_data out DATAW: downstream handshake.
REQ-013 wb_valid, wb_eop in 1; wb_wis, wb_rd in matching widths: register release.
REQ-014 ad_valid in 1, ad_wis, ad_id in matching widths: async completion.

Function
REQ-015 Issue fire = in_valid && in_ready; operands_ready = rs1/rs2/rs3 counters zero && rd-check && async-check.
REQ-016 rd-check: ALLOW_WAW=0 -> rd counter zero; ALLOW_WAW=1 -> rd counter < max.
REQ-017 async-check: in_async_wait -> counter[in_wis][in_async_id] == 0; in_async_start -> counter < ASYNC_DEPTH; else true.
REQ-018 Register 0 SHALL never be busy; increments to rd 0 are discarded.
REQ-019 in_ready = operands_ready && staging ready; in_ready SHALL NOT depend on out_ready combinationally.
REQ-020 Fire with in_wb increments counter[in_wis][in_rd]; wb_valid && wb_eop decrements counter[wb_wis][wb_rd].
REQ-021 Same-cycle increment and decrement of one entry SHALL leave it unchanged.
REQ-022 Decrement of a zero counter SHALL hold zero.
REQ-023 Fire with in_async_start increments async counter[in_wis][in_async_id]; ad_valid decrements counter[ad_wis][ad_id]; simultaneous same entry unchanged.
REQ-024 Counter updates visible to the check the cycle after the event (no same-cycle bypass).
REQ-025 Staging: 2-entry skid buffer; out_valid earliest 1 cycle after fire; order preserved; full throughput with out_ready high.
REQ-026 Stall by busy operand SHALL NOT drop or reorder in_data; in_data may change while stalled.

Reset
REQ-027 Reset clears all register and async counters, empties staging buffer; out_valid=0, in_ready reflects empty state from the first post-reset cycle.
REQ-028 Reset mid-operation discards staged entries and outstanding counts; later wb/ad events on cleared entries hold zero per REQ-022.

Configuration
REQ-029 Macro SCB_PERF_EN adds outputs perf_stalls, perf_fires, perf_waw_issues (PERF_CTR_BITS each), cleared on reset, incremented per valid&&!ready cycle, per fire, per fire with nonzero rd counter.
REQ-030 Without SCB_PERF_EN those ports and logic SHALL be absent; functional behaviour identical.

Structure
REQ-031 Counter-max and async-depth localparams and the clog2 width helpers belong in VX_gpu_pkg.
REQ-032 Staging buffer SHALL be the existing sub-module VX_stream_buffer; no other sub-modules.
REQ-033 Under SIMULATION: assertion on decrement of zero counter and on stall exceeding STALL_TIMEOUT.

Verification
REQ-034 Issue wis=1 rd=5 wb=1, then rs1=5 same warp -> second stalls until wb_eop wis=1 rd=5, fires one cycle later.
REQ-035 ALLOW_WAW=1, CNT_W=2: four issues writing rd=7 -> first three fire, fourth stalls; one wb rd=7 -> fourth fires.
REQ-036 Same-cycle fire rd=3 and wb rd=3 with counter=1 -> counter stays 1; rs1=3 still stalls.
REQ-037 async_start id=1 wis=2, then async_wait id=1 wis=2 -> wait stalls; ad_valid id=1 wis=2 -> wait fires; wis=0 wait never stalls.
REQ-038 out_ready low 3 cycles, 3 independent issues -> 2 accepted, third stalls; release -> in-order output of all 3.
REQ-039 Reset asserted with counters nonzero and 2 staged -> out_valid=0 next cycle, all operands ready.
